player_ctl_l: RTL and testbench

Frame-rate motion and pose controller for the left player. Once per video frame it samples the player's control inputs and advances the player's position, jump, leg-animation, sword-height and sword-thrust state. Its registered outputs drive the left-player sprite renderer's position and pose inputs (`LP_x_pos`, `LP_y_pos`, `change_legs_L`, `sword_pos`, `x_sword_pos`), so it is the producer side of that interface.

---
 rtl/player_ctl_l_pkg.sv | 42 ++++
 rtl/player_ctl_l_frame_tick_gen.sv | 18 +
 rtl/player_ctl_l.sv | 211 +++++++++++++++++++++
 tb/tb_player_ctl_l.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_ctl_l_pkg.sv
// Shared game definitions for the player controllers: FSM encodings,
// guard-level to sword_pos mapping and the screen geometry behind X_MAX.
package player_ctl_l_pkg;

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        ASCEND  = 2'd1,
        DESCEND = 2'd2
    } jump_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_OUT  = 2'd1,
        T_BACK = 2'd2
    } thrust_state_t;

    localparam logic [1:0] GUARD_HIGH = 2'd0;
    localparam logic [1:0] GUARD_MID  = 2'd1;
    localparam logic [1:0] GUARD_LOW  = 2'd2;

    localparam int unsigned SWORD_HIGH_POS = 0;
    localparam int unsigned SWORD_MID_POS  = 10;
    localparam int unsigned SWORD_LOW_POS  = 20;

    localparam int unsigned PLAYER_ORIGIN  = 75;
    localparam int unsigned SPRITE_W       = 64;
    localparam int unsigned FIELD_RIGHT    = 966;
    localparam int unsigned THRUST_LEN_DEF = 16;
    // Rightmost offset that keeps origin + sprite + full thrust on the field.
    localparam int unsigned X_MAX_DEF = FIELD_RIGHT - PLAYER_ORIGIN - SPRITE_W - THRUST_LEN_DEF;

    function automatic logic [4:0] guard_to_pos(input logic [1:0] level,
                                                input logic [4:0] mid,
                                                input logic [4:0] low);
        logic [4:0] pos;
        pos = 5'(SWORD_HIGH_POS);
        if (level == GUARD_MID) pos = mid;
        else if (level == GUARD_LOW) pos = low;
        return pos;
    endfunction

endpackage

// File: rtl/player_ctl_l_frame_tick_gen.sv
// Rising-edge detector on vsync: one-cycle frame tick per frame.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) vsync_d <= 1'b0;
        else       vsync_d <= vsync_in;
    end

    assign tick = vsync_in & ~vsync_d;

endmodule

// File: rtl/player_ctl_l.sv
// Left-player motion and pose controller: per-frame position, jump, leg
// animation, sword guard and thrust state feeding the sprite renderer.
module player_ctl_l
    import player_ctl_l_pkg::*;
#(
    parameter int unsigned X_MAX       = X_MAX_DEF,
    parameter int unsigned STEP        = 4,
    parameter int unsigned JUMP_H      = 96,
    parameter int unsigned JUMP_STEP   = 6,
    parameter int unsigned LEG_PERIOD  = 8,
    parameter int unsigned SWORD_MID   = SWORD_MID_POS,
    parameter int unsigned SWORD_LOW   = SWORD_LOW_POS,
    parameter int unsigned THRUST_LEN  = THRUST_LEN_DEF,
    parameter int unsigned THRUST_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        jump,
    input  logic        sword_up,
    input  logic        sword_down,
    input  logic        thrust,
    output logic [11:0] LP_x_pos,
    output logic [11:0] LP_y_pos,
    output logic        change_legs_L,
    output logic [4:0]  sword_pos,
    output logic [11:0] x_sword_pos,
    output logic        airborne
);

    localparam logic [12:0] STEP_W13 = 13'(STEP);
    localparam logic [12:0] XMAX_W13 = 13'(X_MAX);
    localparam logic [11:0] STEP_W   = 12'(STEP);
    localparam logic [11:0] XMAX_W   = 12'(X_MAX);
    localparam logic [12:0] JSTEP13  = 13'(JUMP_STEP);
    localparam logic [12:0] JH13     = 13'(JUMP_H);
    localparam logic [11:0] JSTEP_W  = 12'(JUMP_STEP);
    localparam logic [11:0] JH_W     = 12'(JUMP_H);
    localparam logic [12:0] TSTEP13  = 13'(THRUST_STEP);
    localparam logic [12:0] TLEN13   = 13'(THRUST_LEN);
    localparam logic [11:0] TSTEP_W  = 12'(THRUST_STEP);
    localparam logic [11:0] TLEN_W   = 12'(THRUST_LEN);
    localparam logic [2:0]  LEG_LAST = 3'(LEG_PERIOD - 1);
    localparam logic [4:0]  MID_W    = 5'(SWORD_MID);
    localparam logic [4:0]  LOW_W    = 5'(SWORD_LOW);

    logic tick;

    frame_tick_gen u_tick (
        .clk      (clk),
        .reset    (reset),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    jump_state_t   jst_q, jst_d;
    thrust_state_t tst_q, tst_d;
    logic [11:0]   x_q, x_d, y_q, y_d, xs_q, xs_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          legs_q, legs_d;
    logic [1:0]    lvl_q, lvl_d;
    logic [4:0]    sword_q, sword_d;
    logic          prev_j_q, prev_j_d, prev_su_q, prev_su_d;
    logic          prev_sd_q, prev_sd_d, prev_th_q, prev_th_d;

    logic          press_j, press_su, press_sd, press_th;
    logic [12:0]   x_sum, y_sum, xs_sum;
    logic          walk_one;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jst_q     <= GROUND;
            tst_q     <= T_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            xs_q      <= '0;
            cnt_q     <= '0;
            legs_q    <= 1'b0;
            lvl_q     <= GUARD_HIGH;
            sword_q   <= '0;
            prev_j_q  <= 1'b0;
            prev_su_q <= 1'b0;
            prev_sd_q <= 1'b0;
            prev_th_q <= 1'b0;
        end else begin
            jst_q     <= jst_d;
            tst_q     <= tst_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xs_q      <= xs_d;
            cnt_q     <= cnt_d;
            legs_q    <= legs_d;
            lvl_q     <= lvl_d;
            sword_q   <= sword_d;
            prev_j_q  <= prev_j_d;
            prev_su_q <= prev_su_d;
            prev_sd_q <= prev_sd_d;
            prev_th_q <= prev_th_d;
        end
    end

    always_comb begin
        jst_d     = jst_q;
        tst_d     = tst_q;
        x_d       = x_q;
        y_d       = y_q;
        xs_d      = xs_q;
        cnt_d     = cnt_q;
        legs_d    = legs_q;
        lvl_d     = lvl_q;
        sword_d   = sword_q;
        prev_j_d  = prev_j_q;
        prev_su_d = prev_su_q;
        prev_sd_d = prev_sd_q;
        prev_th_d = prev_th_q;

        press_j  = jump & ~prev_j_q;
        press_su = sword_up & ~prev_su_q;
        press_sd = sword_down & ~prev_sd_q;
        press_th = thrust & ~prev_th_q;
        walk_one = move_left ^ move_right;
        x_sum    = {1'b0, x_q} + STEP_W13;
        y_sum    = {1'b0, y_q} + JSTEP13;
        xs_sum   = {1'b0, xs_q} + TSTEP13;

        if (tick) begin
            prev_j_d  = jump;
            prev_su_d = sword_up;
            prev_sd_d = sword_down;
            prev_th_d = thrust;

            if (move_right && !move_left)
                x_d = (x_sum > XMAX_W13) ? XMAX_W : x_sum[11:0];
            else if (move_left && !move_right)
                x_d = (x_q < STEP_W) ? '0 : x_q - STEP_W;

            // Legs animate only when walking on the ground (pre-update jump state).
            if (jst_q == GROUND && walk_one) begin
                if (cnt_q == LEG_LAST) begin
                    cnt_d  = '0;
                    legs_d = ~legs_q;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end else begin
                cnt_d  = '0;
                legs_d = 1'b0;
            end

            case (jst_q)
                GROUND: if (press_j) jst_d = ASCEND;
                ASCEND: begin
                    if (y_sum >= JH13) begin
                        y_d   = JH_W;
                        jst_d = DESCEND;
                    end else begin
                        y_d = y_sum[11:0];
                    end
                end
                DESCEND: begin
                    if (y_q <= JSTEP_W) begin
                        y_d   = '0;
                        jst_d = GROUND;
                    end else begin
                        y_d = y_q - JSTEP_W;
                    end
                end
                default: jst_d = GROUND;
            endcase

            if (tst_q == T_IDLE) begin
                if (press_sd && !press_su && lvl_q != GUARD_LOW)
                    lvl_d = lvl_q + 2'd1;
                else if (press_su && !press_sd && lvl_q != GUARD_HIGH)
                    lvl_d = lvl_q - 2'd1;
            end
            sword_d = guard_to_pos(lvl_d, MID_W, LOW_W);

            case (tst_q)
                T_IDLE: if (press_th) tst_d = T_OUT;
                T_OUT: begin
                    if (xs_sum >= TLEN13) begin
                        xs_d  = TLEN_W;
                        tst_d = T_BACK;
                    end else begin
                        xs_d = xs_sum[11:0];
                    end
                end
                T_BACK: begin
                    if (xs_q <= TSTEP_W) begin
                        xs_d  = '0;
                        tst_d = T_IDLE;
                    end else begin
                        xs_d = xs_q - TSTEP_W;
                    end
                end
                default: tst_d = T_IDLE;
            endcase
        end
    end

    assign LP_x_pos      = x_q;
    assign LP_y_pos      = y_q;
    assign change_legs_L = legs_q;
    assign sword_pos     = sword_q;
    assign x_sword_pos   = xs_q;
    assign airborne      = (jst_q != GROUND);

endmodule

// File: tb/tb_player_ctl_l.sv
// Scoreboard bench for player_ctl_l: a frame-level model pushes expected
// outputs per frame; a monitor pops and compares on every observed tick.
module tb_player_ctl_l;

    localparam int X_MAX = 811;
    localparam int STEP = 4;
    localparam int JUMP_H = 96;
    localparam int JUMP_STEP = 6;
    localparam int THRUST_LEN = 16;
    localparam int THRUST_STEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        move_left = 1'b0, move_right = 1'b0, jump = 1'b0;
    logic        sword_up = 1'b0, sword_down = 1'b0, thrust = 1'b0;
    logic [11:0] LP_x_pos, LP_y_pos, x_sword_pos;
    logic        change_legs_L, airborne;
    logic [4:0]  sword_pos;

    player_ctl_l dut (
        .clk           (clk),
        .reset         (reset),
        .vsync_in      (vsync_in),
        .move_left     (move_left),
        .move_right    (move_right),
        .jump          (jump),
        .sword_up      (sword_up),
        .sword_down    (sword_down),
        .thrust        (thrust),
        .LP_x_pos      (LP_x_pos),
        .LP_y_pos      (LP_y_pos),
        .change_legs_L (change_legs_L),
        .sword_pos     (sword_pos),
        .x_sword_pos   (x_sword_pos),
        .airborne      (airborne)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x; int y; bit legs; int sword; int xs; bit air;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // frame-level reference state
    int m_x, m_y, m_js, m_cnt, m_lvl, m_ts, m_xs;
    bit m_legs, m_pj, m_psu, m_psd, m_pth;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_js = 0; m_cnt = 0; m_lvl = 0; m_ts = 0; m_xs = 0;
        m_legs = 0; m_pj = 0; m_psu = 0; m_psd = 0; m_pth = 0;
    endtask

    task automatic model_step(input bit l, r, j, su, sd, th);
        bit pj, psu, psd, pth;
        exp_t e;
        pj = j && !m_pj; psu = su && !m_psu; psd = sd && !m_psd; pth = th && !m_pth;
        m_pj = j; m_psu = su; m_psd = sd; m_pth = th;
        if (r && !l) m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
        else if (l && !r) m_x = (m_x < STEP) ? 0 : m_x - STEP;
        if (m_js == 0 && (l != r)) begin
            if (m_cnt == 7) begin m_cnt = 0; m_legs = !m_legs; end
            else m_cnt++;
        end else begin
            m_cnt = 0; m_legs = 0;
        end
        if (m_js == 0) begin
            if (pj) m_js = 1;
        end else if (m_js == 1) begin
            if (m_y + JUMP_STEP >= JUMP_H) begin m_y = JUMP_H; m_js = 2; end
            else m_y += JUMP_STEP;
        end else begin
            if (m_y <= JUMP_STEP) begin m_y = 0; m_js = 0; end
            else m_y -= JUMP_STEP;
        end
        if (m_ts == 0) begin
            if (psd && !psu && m_lvl < 2) m_lvl++;
            else if (psu && !psd && m_lvl > 0) m_lvl--;
        end
        if (m_ts == 0) begin
            if (pth) m_ts = 1;
        end else if (m_ts == 1) begin
            if (m_xs + THRUST_STEP >= THRUST_LEN) begin m_xs = THRUST_LEN; m_ts = 2; end
            else m_xs += THRUST_STEP;
        end else begin
            if (m_xs <= THRUST_STEP) begin m_xs = 0; m_ts = 0; end
            else m_xs -= THRUST_STEP;
        end
        e.x = m_x; e.y = m_y; e.legs = m_legs; e.xs = m_xs; e.air = (m_js != 0);
        e.sword = (m_lvl == 0) ? 0 : (m_lvl == 1) ? 10 : 20;
        q.push_back(e);
    endtask

    // One frame: inputs and vsync rise at a negedge, vsync held for 'hold' clocks.
    task automatic frame(input bit l, r, j, su, sd, th, input int hold = 1);
        model_step(l, r, j, su, sd, th);
        @(negedge clk);
        move_left = l; move_right = r; jump = j;
        sword_up = su; sword_down = sd; thrust = th;
        vsync_in = 1'b1;
        repeat (hold) @(negedge clk);
        vsync_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    logic vs_q;
    always @(posedge clk or posedge reset) begin
        if (reset) vs_q <= 1'b0;
        else       vs_q <= vsync_in;
    end

    always @(posedge clk) begin
        if (!reset && vsync_in && !vs_q) begin
            #1;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL tick_unexpected: got tick with x=%0d, required no tick", LP_x_pos);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (LP_x_pos !== 12'(e.x) || LP_y_pos !== 12'(e.y) || change_legs_L !== e.legs ||
                    sword_pos !== 5'(e.sword) || x_sword_pos !== 12'(e.xs) || airborne !== e.air) begin
                    n_err++;
                    $display("FAIL tick_outputs: got x=%0d y=%0d legs=%0b sword=%0d xs=%0d air=%0b, required x=%0d y=%0d legs=%0b sword=%0d xs=%0d air=%0b",
                             LP_x_pos, LP_y_pos, change_legs_L, sword_pos, x_sword_pos, airborne,
                             e.x, e.y, e.legs, e.sword, e.xs, e.air);
                end
            end
        end
    end

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (LP_x_pos !== 0 || LP_y_pos !== 0 || change_legs_L !== 0 || sword_pos !== 0 ||
            x_sword_pos !== 0 || airborne !== 0) begin
            n_err++;
            $display("FAIL reset_state: got x=%0d y=%0d legs=%0b sword=%0d xs=%0d air=%0b, required all 0",
                     LP_x_pos, LP_y_pos, change_legs_L, sword_pos, x_sword_pos, airborne);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_walk();
        for (int k = 1; k <= 10; k++) begin
            frame(0, 1, 0, 0, 0, 0);
            if (k == 7 || k == 8) begin
                n_vec++;
                if (change_legs_L !== (k == 8)) begin
                    n_err++;
                    $display("FAIL walk_legs_tick%0d: got %0b, required %0b", k, change_legs_L, k == 8);
                end
            end
        end
        n_vec++;
        if (LP_x_pos !== 12'd40) begin
            n_err++;
            $display("FAIL walk_x40: got %0d, required 40", LP_x_pos);
        end
        frame(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (change_legs_L !== 1'b0 || LP_x_pos !== 12'd40) begin
            n_err++;
            $display("FAIL walk_release: got legs=%0b x=%0d, required legs=0 x=40", change_legs_L, LP_x_pos);
        end
    endtask

    task automatic test_x_bounds();
        for (int k = 0; k < 192; k++) frame(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (LP_x_pos !== 12'd808) begin
            n_err++;
            $display("FAIL x_preset: got %0d, required 808", LP_x_pos);
        end
        for (int k = 0; k < 2; k++) begin
            frame(0, 1, 0, 0, 0, 0);
            n_vec++;
            if (LP_x_pos !== 12'd811) begin
                n_err++;
                $display("FAIL x_clamp_max: got %0d, required 811", LP_x_pos);
            end
        end
        frame(1, 1, 0, 0, 0, 0);
        n_vec++;
        if (LP_x_pos !== 12'd811 || change_legs_L !== 1'b0) begin
            n_err++;
            $display("FAIL x_both_held: got x=%0d legs=%0b, required x=811 legs=0", LP_x_pos, change_legs_L);
        end
        for (int k = 0; k < 202; k++) frame(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (LP_x_pos !== 12'd3) begin
            n_err++;
            $display("FAIL x_left_walk: got %0d, required 3", LP_x_pos);
        end
        for (int k = 0; k < 2; k++) begin
            frame(1, 0, 0, 0, 0, 0);
            n_vec++;
            if (LP_x_pos !== 12'd0) begin
                n_err++;
                $display("FAIL x_clamp_zero: got %0d, required 0", LP_x_pos);
            end
        end
        frame(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_jump();
        int ey;
        frame(0, 0, 1, 0, 0, 0);
        n_vec++;
        if (airborne !== 1'b1 || LP_y_pos !== 12'd0) begin
            n_err++;
            $display("FAIL jump_press: got air=%0b y=%0d, required air=1 y=0", airborne, LP_y_pos);
        end
        for (int k = 1; k <= 32; k++) begin
            frame(0, 0, (k == 5), 0, 0, 0);
            ey = (k <= 16) ? 6 * k : 96 - 6 * (k - 16);
            n_vec++;
            if (LP_y_pos !== 12'(ey) || airborne !== (k < 32)) begin
                n_err++;
                $display("FAIL jump_tick%0d: got y=%0d air=%0b, required y=%0d air=%0b",
                         k, LP_y_pos, airborne, ey, k < 32);
            end
        end
    endtask

    task automatic test_sword();
        int exp_pos[4] = '{10, 20, 20, 10};
        for (int k = 0; k < 4; k++) begin
            frame(0, 0, 0, (k == 3), (k != 3), 0);
            n_vec++;
            if (sword_pos !== 5'(exp_pos[k])) begin
                n_err++;
                $display("FAIL sword_press%0d: got %0d, required %0d", k, sword_pos, exp_pos[k]);
            end
            frame(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_thrust();
        int exp_xs[8] = '{4, 8, 12, 16, 12, 8, 4, 0};
        frame(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 8; k++) begin
            frame(0, 0, 0, 0, (k == 3), (k == 5));
            n_vec++;
            if (x_sword_pos !== 12'(exp_xs[k-1]) || sword_pos !== 5'd10) begin
                n_err++;
                $display("FAIL thrust_tick%0d: got xs=%0d sword=%0d, required xs=%0d sword=10",
                         k, x_sword_pos, sword_pos, exp_xs[k-1]);
            end
        end
        frame(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_and_held_vsync();
        frame(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) frame(0, 0, 0, 0, 0, (k == 6));
        n_vec++;
        if (LP_y_pos !== 12'd48 || x_sword_pos !== 12'd8) begin
            n_err++;
            $display("FAIL pre_reset_state: got y=%0d xs=%0d, required y=48 xs=8", LP_y_pos, x_sword_pos);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (LP_x_pos !== 0 || LP_y_pos !== 0 || change_legs_L !== 0 || sword_pos !== 0 ||
            x_sword_pos !== 0 || airborne !== 0) begin
            n_err++;
            $display("FAIL async_reset: got x=%0d y=%0d legs=%0b sword=%0d xs=%0d air=%0b, required all 0",
                     LP_x_pos, LP_y_pos, change_legs_L, sword_pos, x_sword_pos, airborne);
        end
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        frame(0, 1, 0, 0, 0, 0, 100);
        n_vec++;
        if (LP_x_pos !== 12'd4 || q.size() != 0) begin
            n_err++;
            $display("FAIL vsync_held: got x=%0d pending=%0d, required x=4 pending=0", LP_x_pos, q.size());
        end
        frame(0, 1, 0, 0, 0, 0);
        n_vec++;
        if (LP_x_pos !== 12'd8) begin
            n_err++;
            $display("FAIL after_held: got %0d, required 8", LP_x_pos);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_x_bounds();
        test_jump();
        test_sword();
        test_thrust();
        test_reset_mid_and_held_vsync();
        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL missing_ticks: got %0d unconsumed, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
